// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the shared-multiplier scheduler.
package mul_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ACC    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int unsigned DEF_W    = 16;
  localparam int unsigned DEF_NREQ = 4;

  // Index width for n clients, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_rr_arb.sv
// Combinational round-robin pick: first requester at or after the pointer.
module mul_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_vld
);

  int unsigned w_sum;
  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_sum = 0;
    w_j   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = 32'(i_ptr) + k;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_j = IW'(w_sum);
      if (!o_vld && i_req[w_j]) begin
        o_vld      = 1'b1;
        o_idx      = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler driving a shared repeated-addition multiplier datapath.
// Optional operand swap (shorter loop count) under MUL_SHARE_SCHED_SWAP_EN.
module mul_share_sched
  import mul_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned W    = DEF_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [W-1:0]    result,
  output logic            busy,
  output logic [W-1:0]    dp_bus,
  output logic            lda,
  output logic            ldb,
  output logic            clrp,
  output logic            ldp,
  output logic            decb,
  input  logic            dp_eqz,
  input  logic [W-1:0]    dp_p
);

  localparam int unsigned IW = idx_w(NREQ);

  state_t          r_state;
  logic [IW-1:0]   r_g;
  logic [IW-1:0]   r_ptr;
  logic            r_swap;

  logic [NREQ-1:0] w_win_oh;
  logic [IW-1:0]   w_win_idx;
  logic            w_win_vld;
  logic [W-1:0]    w_win_a;
  logic [W-1:0]    w_win_b;
  logic [W-1:0]    w_g_a;
  logic [W-1:0]    w_g_b;
  logic            w_swap;

  mul_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_win_oh),
    .o_idx (w_win_idx),
    .o_vld (w_win_vld)
  );

  assign w_win_a = a_in[w_win_idx*W +: W];
  assign w_win_b = b_in[w_win_idx*W +: W];
  assign w_g_a   = a_in[r_g*W +: W];
  assign w_g_b   = b_in[r_g*W +: W];

`ifdef MUL_SHARE_SCHED_SWAP_EN
  assign w_swap = (w_win_b > w_win_a);
`else
  assign w_swap = 1'b0;
`endif

  // Accumulate only while the B counter is non-zero.
  assign ldp  = (r_state == ACC) && !dp_eqz;
  assign decb = (r_state == ACC) && !dp_eqz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
      r_swap  <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      result  <= '0;
      busy    <= 1'b0;
      dp_bus  <= '0;
      lda     <= 1'b0;
      ldb     <= 1'b0;
      clrp    <= 1'b0;
    end else begin
      lda    <= 1'b0;
      ldb    <= 1'b0;
      clrp   <= 1'b0;
      done   <= '0;
      dp_bus <= '0;
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_state <= LOAD_A;
            r_g     <= w_win_idx;
            r_swap  <= w_swap;
            gnt     <= w_win_oh;
            busy    <= 1'b1;
            lda     <= 1'b1;
            dp_bus  <= w_swap ? w_win_b : w_win_a;
          end
        end
        LOAD_A: begin
          r_state <= LOAD_B;
          ldb     <= 1'b1;
          clrp    <= 1'b1;
          dp_bus  <= r_swap ? w_g_a : w_g_b;
        end
        LOAD_B: r_state <= ACC;
        ACC: begin
          if (dp_eqz) begin
            r_state <= DONE;
            result  <= dp_p;
            done    <= gnt;
          end
        end
        DONE: begin
          r_state <= IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
          r_ptr   <= (32'(r_g) == NREQ - 1) ? '0 : IW'(32'(r_g) + 1);
        end
        default: begin
          r_state <= IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched with a behavioural multiplier datapath.
module tb_mul_share_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 16;

  typedef struct {
    int          idx;
    logic [15:0] res;
    int          lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] a_in = '0;
  logic [NREQ*W-1:0] b_in = '0;
  logic [NREQ-1:0] gnt, done;
  logic [W-1:0]    result, dp_bus, dp_p;
  logic            busy, lda, ldb, clrp, ldp, decb, dp_eqz;

  logic [W-1:0] m_a, m_b, m_p;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  exp_t sb[$];

  mul_share_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .busy(busy), .dp_bus(dp_bus),
    .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .decb(decb),
    .dp_eqz(dp_eqz), .dp_p(dp_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath: A register, B down-counter, P accumulator.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; m_p <= '0;
    end else begin
      if (lda) m_a <= dp_bus;
      if (ldb) m_b <= dp_bus;
      else if (decb) m_b <= m_b - 16'd1;
      if (clrp) m_p <= '0;
      else if (ldp) m_p <= m_p + m_a;
    end
  end
  assign dp_eqz = (m_b == '0);
  assign dp_p   = m_p;

  always @(negedge clk) begin
    if (ldp || decb) acc_cnt <= acc_cnt + 1;
    if (busy) begin
      n_chk++;
      if ((ldp && dp_eqz) || (ldp != decb)) begin
        n_fail++;
        $display("FAIL acc_ctrl: ldp=%b decb=%b dp_eqz=%b", ldp, decb, dp_eqz);
      end
    end
  end

  function automatic int exp_lat(input int a, input int b);
`ifdef MUL_SHARE_SCHED_SWAP_EN
    return ((b > a) ? a : b) + 4;
`else
    return b + 4;
`endif
  endfunction

  task automatic set_ops(input int c, input logic [15:0] a, input logic [15:0] b);
    a_in[c*W +: W] = a;
    b_in[c*W +: W] = b;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen, output int at_cyc);
    seen = 0;
    at_cyc = 0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(posedge clk); #1;
      if (|done) begin seen = 1; at_cyc = cyc; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_chk++;
    if ({gnt, done, result, busy, dp_bus, lda, ldb, clrp, ldp, decb} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {gnt, done, result, busy, dp_bus, lda, ldb, clrp, ldp, decb});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit seen; int t0, td; exp_t e;
    set_ops(0, 16'd7, 16'd5);
    req = 4'b0001; t0 = cyc;
    sb.push_back('{0, 16'd35, exp_lat(7, 5)});
    @(posedge clk); #1;
    n_chk++;
    if (gnt !== 4'b0001 || lda !== 1'b1 || dp_bus !== 16'd7 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_a: gnt=%b lda=%b bus=%0d busy=%b expected 0001 1 7 1", gnt, lda, dp_bus, busy);
    end
    @(posedge clk); #1;
    n_chk++;
    if (ldb !== 1'b1 || clrp !== 1'b1 || lda !== 1'b0 || dp_bus !== 16'd5) begin
      n_fail++;
      $display("FAIL load_b: ldb=%b clrp=%b lda=%b bus=%0d expected 1 1 0 5", ldb, clrp, lda, dp_bus);
    end
    wait_done(40, seen, td);
    e = sb.pop_front();
    n_chk++;
    if (!seen || done !== 4'(1 << e.idx) || result !== e.res || td - t0 != e.lat) begin
      n_fail++;
      $display("FAIL single: seen=%0d done=%b res=%0d lat=%0d expected done=%b res=%0d lat=%0d",
               seen, done, result, td - t0, 4'(1 << e.idx), e.res, e.lat);
    end
    req = '0;
    @(posedge clk); #1;
    n_chk++;
    if (done !== '0 || gnt !== '0 || busy !== 1'b0 || result !== 16'd35) begin
      n_fail++;
      $display("FAIL after_done: done=%b gnt=%b busy=%b res=%0d expected 0 0 0 35", done, gnt, busy, result);
    end
  endtask

  task automatic test_b_zero();
    bit seen; int t0, td; exp_t e;
    set_ops(0, 16'd123, 16'd0);
    acc_cnt = 0;
    req = 4'b0001; t0 = cyc;
    sb.push_back('{0, 16'd0, 4});
    wait_done(20, seen, td);
    e = sb.pop_front();
    n_chk++;
    if (!seen || done !== 4'(1 << e.idx) || result !== e.res || td - t0 != e.lat) begin
      n_fail++;
      $display("FAIL b_zero: seen=%0d done=%b res=%0d lat=%0d expected res=%0d lat=%0d",
               seen, done, result, td - t0, e.res, e.lat);
    end
    req = '0;
    n_chk++;
    if (acc_cnt != 0) begin
      n_fail++;
      $display("FAIL b_zero_acc: ldp/decb cycles=%0d expected 0", acc_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_swap();
    bit seen; int t0, td; exp_t e;
    set_ops(0, 16'h0100, 16'h0100);
    req = 4'b0001; t0 = cyc;
    sb.push_back('{0, 16'h0000, exp_lat(256, 256)});
    wait_done(400, seen, td);
    e = sb.pop_front();
    n_chk++;
    if (!seen || result !== e.res || td - t0 != e.lat) begin
      n_fail++;
      $display("FAIL wrap: seen=%0d res=%h lat=%0d expected res=%h lat=%0d", seen, result, td - t0, e.res, e.lat);
    end
    req = '0;
    @(posedge clk); #1;
    set_ops(0, 16'd3, 16'd1000);
    req = 4'b0001; t0 = cyc;
    sb.push_back('{0, 16'd3000, exp_lat(3, 1000)});
    wait_done(1100, seen, td);
    e = sb.pop_front();
    n_chk++;
    if (!seen || result !== e.res || td - t0 != e.lat) begin
      n_fail++;
      $display("FAIL swap: seen=%0d res=%0d lat=%0d expected res=%0d lat=%0d", seen, result, td - t0, e.res, e.lat);
    end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit seen; int tref, td; exp_t e;
    rst = 1'b1; #1; rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      set_ops(i, 16'(i + 2), 16'd3);
      sb.push_back('{i, 16'((i + 2) * 3), (i == 0) ? exp_lat(i + 2, 3) : exp_lat(i + 2, 3) + 1});
    end
    req = 4'b1111; tref = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_done(30, seen, td);
      e = sb.pop_front();
      n_chk++;
      if (!seen || done !== 4'(1 << e.idx) || result !== e.res || td - tref != e.lat) begin
        n_fail++;
        $display("FAIL b2b_%0d: seen=%0d done=%b res=%0d gap=%0d expected done=%b res=%0d gap=%0d",
                 i, seen, done, result, td - tref, 4'(1 << e.idx), e.res, e.lat);
      end
      req[e.idx] = 1'b0;
      tref = td;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen; int t0, td; exp_t e;
    set_ops(0, 16'd9, 16'd10);
    req = 4'b0001;
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b1 || ldp !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_acc: busy=%b ldp=%b expected 1 1", busy, ldp);
    end
    rst = 1'b1; #1;
    n_chk++;
    if ({gnt, done, result, busy, dp_bus, lda, ldb, clrp, ldp, decb} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h expected 0",
               {gnt, done, result, busy, dp_bus, lda, ldb, clrp, ldp, decb});
    end
    req = '0;
    @(posedge clk); #1 rst = 1'b0;
    wait_done(20, seen, td);
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL no_done: done pulse seen=%0d expected 0", seen);
    end
    set_ops(2, 16'd6, 16'd7);
    req = 4'b0100; t0 = cyc;
    sb.push_back('{2, 16'd42, exp_lat(6, 7)});
    wait_done(30, seen, td);
    e = sb.pop_front();
    n_chk++;
    if (!seen || done !== 4'(1 << e.idx) || result !== e.res || td - t0 != e.lat) begin
      n_fail++;
      $display("FAIL post_reset: seen=%0d done=%b res=%0d lat=%0d expected done=%b res=%0d lat=%0d",
               seen, done, result, td - t0, 4'(1 << e.idx), e.res, e.lat);
    end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_drop_req();
    bit seen; int td; exp_t e;
    rst = 1'b1; #1; rst = 1'b0;
    @(posedge clk); #1;
    set_ops(1, 16'd4, 16'd2);
    req = 4'b0010;
    sb.push_back('{1, 16'd8, 0});
    repeat (3) @(posedge clk);
    #1 req = '0;
    wait_done(20, seen, td);
    e = sb.pop_front();
    n_chk++;
    if (!seen || done !== 4'(1 << e.idx) || result !== e.res) begin
      n_fail++;
      $display("FAIL drop_req: seen=%0d done=%b res=%0d expected done=%b res=%0d",
               seen, done, result, 4'(1 << e.idx), e.res);
    end
    @(posedge clk); #1;
    set_ops(2, 16'd5, 16'd1);
    set_ops(1, 16'd5, 16'd2);
    req = 4'b0110;
    sb.push_back('{2, 16'd5, 0});
    sb.push_back('{1, 16'd10, 0});
    for (int i = 0; i < 2; i++) begin
      wait_done(20, seen, td);
      e = sb.pop_front();
      n_chk++;
      if (!seen || done !== 4'(1 << e.idx) || result !== e.res) begin
        n_fail++;
        $display("FAIL ptr_order_%0d: seen=%0d done=%b res=%0d expected done=%b res=%0d",
                 i, seen, done, result, 4'(1 << e.idx), e.res);
      end
      req[e.idx] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_b_zero();
    test_wrap_swap();
    test_back_to_back();
    test_reset_mid();
    test_drop_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
